// File: rtl/ifq_predecode.sv
// Instruction fetch queue: a small circular FIFO of {pc, instr} pairs between fetch and decode,
// with jump/branch/nop pre-decode flags computed on the head entry.
module ifq_predecode #(
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [31:0]      in_pc,
   input  logic [31:0]      in_instr,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic             out_is_beq,
   output logic             out_is_j,
   output logic             out_is_nop,
   output logic [CNT_W-1:0] count
);

   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   logic [31:0]      pc_mem_p0    [DEPTH];
   logic [31:0]      instr_mem_p0 [DEPTH];
   logic [PTR_W-1:0] wr_ptr_p0;
   logic [PTR_W-1:0] rd_ptr_p0;
   logic             push;
   logic             pop;
   logic [5:0]       head_op;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      // DEPTH is a power of two, so natural overflow of the pointer is the modulo wrap
      return p + PTR_W'(1);
   endfunction

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // ---- stage p0: storage, pointers and occupancy ----
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_p0[i]    <= '0;
            instr_mem_p0[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_p0 <= '0;
         rd_ptr_p0 <= '0;
         count     <= '0;
      end else begin
         if (push) begin
            pc_mem_p0[wr_ptr_p0]    <= in_pc;
            instr_mem_p0[wr_ptr_p0] <= in_instr;
            wr_ptr_p0               <= ptr_inc(wr_ptr_p0);
         end
         if (pop) begin
            rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---- head read and pre-decode (combinational from stage p0) ----
   assign out_pc     = out_valid ? pc_mem_p0[rd_ptr_p0]    : '0;
   assign out_instr  = out_valid ? instr_mem_p0[rd_ptr_p0] : '0;
   assign head_op    = out_instr[31:26];
   assign out_is_beq = out_valid & (head_op == OP_BEQ);
   assign out_is_j   = out_valid & (head_op == OP_J);
   assign out_is_nop = out_valid & (out_instr == 32'h0000_0000);

endmodule
